// File: rtl/palette_write_scheduler_if.sv
// Host byte-write bus and palette RAM write port
// grouped for palette_write_scheduler.
interface palette_write_scheduler_if;
  logic        host_wrena;
  logic [19:0] host_addr_in;
  logic [7:0]  host_data_in;
  logic        pal_wrena;
  logic [19:0] pal_addr;
  logic [7:0]  pal_data;

  modport master (
    output host_wrena,
    output host_addr_in,
    output host_data_in,
    input  pal_wrena,
    input  pal_addr,
    input  pal_data
  );

  modport slave (
    input  host_wrena,
    input  host_addr_in,
    input  host_data_in,
    output pal_wrena,
    output pal_addr,
    output pal_data
  );
endinterface

// File: rtl/palette_write_scheduler.sv
// Queues host palette writes and replays them to the palette RAM.
// Define PAL_VBLANK_SYNC_EN to restrict draining to vertical blank.
module palette_write_scheduler #(
  parameter logic [19:0] PALETTE_ADDR = 20'h04000,
  parameter int          FIFO_DEPTH   = 16,
  localparam int         PW = $clog2(FIFO_DEPTH),
  localparam int         LW = PW + 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                vblank,
  input  logic                overflow_clr,
  palette_write_scheduler_if.slave bus,
  output logic                fifo_full,
  output logic [LW-1:0]       fifo_level,
  output logic                overflow,
  output logic                drain_active
);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    DRAIN
  } state_t;

  localparam logic [20:0] WIN_LO = {1'b0, PALETTE_ADDR};
  localparam logic [20:0] WIN_HI = WIN_LO + 21'd1023;

  state_t        state;
  logic [27:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [20:0]   haddr;
  logic          in_win;
  logic          permit;
  logic          full;
  logic          push;
  logic          pop;
  logic          drop;

`ifdef PAL_VBLANK_SYNC_EN
  assign permit = vblank;
`else
  logic unused_vblank;
  assign unused_vblank = vblank;
  assign permit = 1'b1;
`endif

  assign haddr  = {1'b0, bus.host_addr_in};
  assign in_win = (haddr >= WIN_LO) && (haddr <= WIN_HI);
  assign full   = (fifo_level == LW'(FIFO_DEPTH));

  // a full queue still accepts a write when the same cycle frees a slot
  assign pop  = (state == DRAIN) && permit && (fifo_level != '0);
  assign push = bus.host_wrena && in_win && (!full || pop);
  assign drop = bus.host_wrena && in_win && full && !pop;

  assign fifo_full    = full;
  assign drain_active = (state == DRAIN);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {bus.host_addr_in, bus.host_data_in};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_level    <= '0;
      overflow      <= 1'b0;
      bus.pal_wrena <= 1'b0;
      bus.pal_addr  <= '0;
      bus.pal_data  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end

      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase

      bus.pal_wrena <= pop;
      if (pop) begin
        bus.pal_addr <= mem[rd_ptr][27:8];
        bus.pal_data <= mem[rd_ptr][7:0];
      end

      if (overflow_clr) begin
        overflow <= 1'b0;
      end else if (drop) begin
        overflow <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (push) begin
            state <= ARMED;
          end
        end
        ARMED: begin
          if (permit) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!permit) begin
            state <= ARMED;
          end else if (pop && !push && fifo_level == LW'(1)) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_palette_write_scheduler.sv
// Directed bench for palette_write_scheduler; sync-mode steps
// run when PAL_VBLANK_SYNC_EN is defined.
module tb_palette_write_scheduler;

  logic       clk;
  logic       reset_n;
  logic       vblank;
  logic       overflow_clr;
  logic       fifo_full;
  logic [4:0] fifo_level;
  logic       overflow;
  logic       drain_active;
  int         checks;
  int         errors;

  palette_write_scheduler_if bus ();

  palette_write_scheduler dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .vblank       (vblank),
    .overflow_clr (overflow_clr),
    .bus          (bus.slave),
    .fifo_full    (fifo_full),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .drain_active (drain_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [19:0] a, input logic [7:0] d);
    bus.host_wrena   = 1'b1;
    bus.host_addr_in = a;
    bus.host_data_in = d;
    tick();
    bus.host_wrena   = 1'b0;
  endtask

  task automatic chk_pal(input string tag, input logic [19:0] a,
                         input logic [7:0] d);
    chk({tag, "_wrena"}, 32'(bus.pal_wrena), 32'd1);
    chk({tag, "_addr"}, 32'(bus.pal_addr), 32'(a));
    chk({tag, "_data"}, 32'(bus.pal_data), 32'(d));
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    reset_n          = 1'b0;
    vblank           = 1'b0;
    overflow_clr     = 1'b0;
    bus.host_wrena   = 1'b0;
    bus.host_addr_in = '0;
    bus.host_data_in = '0;
    tick();
    tick();
    chk("rst_wrena", 32'(bus.pal_wrena), 32'd0);
    chk("rst_addr", 32'(bus.pal_addr), 32'd0);
    chk("rst_data", 32'(bus.pal_data), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_full", 32'(fifo_full), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_drain", 32'(drain_active), 32'd0);
    reset_n = 1'b1;
    tick();

    wr(20'h03FFF, 8'h01);
    wr(20'h04400, 8'h02);
    tick();
    tick();
    chk("oow_level", 32'(fifo_level), 32'd0);
    chk("oow_wrena", 32'(bus.pal_wrena), 32'd0);
    chk("oow_ovf", 32'(overflow), 32'd0);
    chk("oow_drain", 32'(drain_active), 32'd0);

`ifndef PAL_VBLANK_SYNC_EN
    wr(20'h04010, 8'hA5);
    chk("lat0_level", 32'(fifo_level), 32'd1);
    chk("lat0_wrena", 32'(bus.pal_wrena), 32'd0);
    chk("lat0_drain", 32'(drain_active), 32'd0);
    tick();
    chk("lat1_wrena", 32'(bus.pal_wrena), 32'd0);
    chk("lat1_drain", 32'(drain_active), 32'd1);
    tick();
    chk_pal("lat2", 20'h04010, 8'hA5);
    chk("lat2_level", 32'(fifo_level), 32'd0);
    chk("lat2_drain", 32'(drain_active), 32'd0);
    tick();
    chk("lat3_wrena", 32'(bus.pal_wrena), 32'd0);
    chk("lat3_hold", 32'(bus.pal_addr), 32'h04010);

    wr(20'h043FF, 8'h7E);
    tick();
    tick();
    chk_pal("top_edge", 20'h043FF, 8'h7E);

    wr(20'h04000, 8'h11);
    chk("bst0_level", 32'(fifo_level), 32'd1);
    wr(20'h04001, 8'h22);
    chk("bst1_level", 32'(fifo_level), 32'd2);
    chk("bst1_drain", 32'(drain_active), 32'd1);
    wr(20'h04002, 8'h33);
    chk("bst2_level", 32'(fifo_level), 32'd2);
    chk_pal("bst2", 20'h04000, 8'h11);
    tick();
    chk("bst3_level", 32'(fifo_level), 32'd1);
    chk_pal("bst3", 20'h04001, 8'h22);
    tick();
    chk("bst4_level", 32'(fifo_level), 32'd0);
    chk_pal("bst4", 20'h04002, 8'h33);
    chk("bst4_drain", 32'(drain_active), 32'd0);
    tick();
    chk("bst5_wrena", 32'(bus.pal_wrena), 32'd0);

    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    chk("clr_ovf", 32'(overflow), 32'd0);

    wr(20'h04020, 8'h01);
    wr(20'h04021, 8'h02);
    wr(20'h04022, 8'h03);
    chk_pal("mid_pop", 20'h04020, 8'h01);
    reset_n = 1'b0;
    tick();
    chk("mrst_wrena", 32'(bus.pal_wrena), 32'd0);
    chk("mrst_level", 32'(fifo_level), 32'd0);
    chk("mrst_drain", 32'(drain_active), 32'd0);
    chk("mrst_addr", 32'(bus.pal_addr), 32'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_quiet", 32'(bus.pal_wrena), 32'd0);
    end
    wr(20'h04055, 8'hC3);
    tick();
    chk("after_rst_lat1", 32'(bus.pal_wrena), 32'd0);
    tick();
    chk_pal("after_rst_lat2", 20'h04055, 8'hC3);
`else
    for (int i = 0; i < 3; i++) begin
      wr(20'h04000 + 20'(i), 8'(i + 1));
      chk("sy_fill_level", 32'(fifo_level), 32'(i + 1));
    end
    tick();
    tick();
    chk("sy_hold_wrena", 32'(bus.pal_wrena), 32'd0);
    chk("sy_hold_level", 32'(fifo_level), 32'd3);
    chk("sy_hold_drain", 32'(drain_active), 32'd0);
    vblank = 1'b1;
    tick();
    chk("sy_arm_drain", 32'(drain_active), 32'd1);
    chk("sy_arm_wrena", 32'(bus.pal_wrena), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_pal("sy_pop", 20'h04000 + 20'(i), 8'(i + 1));
    end
    chk("sy_end_level", 32'(fifo_level), 32'd0);
    chk("sy_end_drain", 32'(drain_active), 32'd0);
    tick();
    chk("sy_end_wrena", 32'(bus.pal_wrena), 32'd0);
    vblank = 1'b0;

    for (int i = 0; i < 17; i++) begin
      wr(20'h04100 + 20'(i), 8'(i));
      if (i == 15) chk("ov_16_ovf", 32'(overflow), 32'd0);
    end
    chk("ov_level", 32'(fifo_level), 32'd16);
    chk("ov_full", 32'(fifo_full), 32'd1);
    chk("ov_flag", 32'(overflow), 32'd1);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    chk("ov_clr", 32'(overflow), 32'd0);
    chk("ov_clr_level", 32'(fifo_level), 32'd16);

    vblank = 1'b1;
    tick();
    chk("pp_drain", 32'(drain_active), 32'd1);
    wr(20'h043AA, 8'hEE);
    chk("pp_level", 32'(fifo_level), 32'd16);
    chk("pp_ovf", 32'(overflow), 32'd0);
    chk_pal("pp_pop0", 20'h04100, 8'h00);
    for (int i = 1; i < 16; i++) begin
      tick();
      chk_pal("pp_pop", 20'h04100 + 20'(i), 8'(i));
    end
    tick();
    chk_pal("pp_last", 20'h043AA, 8'hEE);
    chk("pp_last_level", 32'(fifo_level), 32'd0);
    tick();
    chk("pp_idle_wrena", 32'(bus.pal_wrena), 32'd0);
    chk("pp_idle_drain", 32'(drain_active), 32'd0);
    vblank = 1'b0;

    for (int i = 0; i < 8; i++) begin
      wr(20'h04200 + 20'(i), 8'h80 + 8'(i));
    end
    vblank = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_pal("pt_pop", 20'h04200 + 20'(i), 8'h80 + 8'(i));
    end
    vblank = 1'b0;
    tick();
    chk("pt_int_wrena", 32'(bus.pal_wrena), 32'd0);
    chk("pt_int_level", 32'(fifo_level), 32'd5);
    chk("pt_int_drain", 32'(drain_active), 32'd0);
    tick();
    chk("pt_int2_wrena", 32'(bus.pal_wrena), 32'd0);
    vblank = 1'b1;
    tick();
    chk("pt_rearm_wrena", 32'(bus.pal_wrena), 32'd0);
    for (int i = 3; i < 8; i++) begin
      tick();
      chk_pal("pt_rest", 20'h04200 + 20'(i), 8'h80 + 8'(i));
    end
    tick();
    chk("pt_done_wrena", 32'(bus.pal_wrena), 32'd0);
    chk("pt_done_level", 32'(fifo_level), 32'd0);
    vblank = 1'b0;

    wr(20'h04030, 8'h01);
    wr(20'h04031, 8'h02);
    wr(20'h04032, 8'h03);
    vblank = 1'b1;
    tick();
    tick();
    chk_pal("mid_pop", 20'h04030, 8'h01);
    reset_n = 1'b0;
    tick();
    chk("mrst_wrena", 32'(bus.pal_wrena), 32'd0);
    chk("mrst_level", 32'(fifo_level), 32'd0);
    chk("mrst_drain", 32'(drain_active), 32'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_quiet", 32'(bus.pal_wrena), 32'd0);
    end
    vblank = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/palette_write_scheduler.md
PALETTE_WRITE_SCHEDULER -- requirements
Module: palette_write_scheduler

Interface
REQ-001 SHALL have parameter PALETTE_ADDR, default 20'h04000, base address of the 1024-byte palette window.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, queue entries; power of two, 4..64.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port vblank  input  1  vertical-blank level from the video timing generator.
REQ-006 SHALL have port host_wrena  input  1  one-cycle host byte-write strobe.
REQ-007 SHALL have port host_addr_in  input  20  host byte address.
REQ-008 SHALL have port host_data_in  input  8  host write byte.
REQ-009 SHALL have port pal_wrena  output  1  write strobe to the palette RAM host port.
REQ-010 SHALL have port pal_addr  output  20  write address to the palette RAM host port.
REQ-011 SHALL have port pal_data  output  8  write byte to the palette RAM host port.
REQ-012 SHALL have port fifo_full  output  1  queue holds FIFO_DEPTH entries.
REQ-013 SHALL have port fifo_level  output  $clog2(FIFO_DEPTH)+1  current entry count.
REQ-014 SHALL have port overflow  output  1  sticky flag: an in-window write was dropped.
REQ-015 SHALL have port overflow_clr  input  1  clears overflow.
REQ-016 SHALL have port drain_active  output  1  high while in state DRAIN.

Function
REQ-017 SHALL enqueue {host_addr_in, host_data_in} when host_wrena=1 and PALETTE_ADDR <= host_addr_in <= PALETTE_ADDR+1023.
REQ-018 SHALL ignore host writes outside that window: no enqueue, no flag.
REQ-019 SHALL drop an in-window write that arrives while full with no pop in the same cycle, and set overflow on the next edge.
REQ-020 SHALL accept a push when full if a pop occurs in the same cycle; fifo_level stays unchanged.
REQ-021 SHALL implement FIFO order; read and write pointers wrap modulo FIFO_DEPTH.
REQ-022 SHALL have states IDLE (empty), ARMED (non-empty, drain not permitted) and DRAIN (popping).
REQ-023 SHALL make transitions: IDLE->ARMED on a push; ARMED->DRAIN when drain is permitted; DRAIN->IDLE when the last entry pops; DRAIN->ARMED when permission drops with entries left.
REQ-024 SHALL pop at most one entry per cycle in DRAIN, driving pal_wrena=1 with that entry's addr/data, registered.
REQ-025 SHALL give a minimum latency of 2 cycles from the host_wrena edge to pal_wrena, measured through ARMED.
REQ-026 SHALL drive pal_wrena=0 in every cycle without a pop; pal_addr/pal_data hold their last values.
REQ-027 SHALL never lose or duplicate an entry when drain is interrupted; the remainder drains in the next permitted window.
REQ-028 SHALL accept pushes in all states, including DRAIN.
REQ-029 SHALL let overflow_clr take priority over a same-cycle overflow set (clear wins).

Reset
REQ-030 SHALL on reset_n=0 at a clk edge: pointers=0, fifo_level=0, state=IDLE, and pal_wrena=0, pal_addr=0, pal_data=0, overflow=0, fifo_full=0, drain_active=0.
REQ-031 SHALL discard all queued entries on reset mid-drain; no pal_wrena in the cycle after reset is asserted.

Configuration
REQ-032 SHALL gate drain permission with macro PAL_VBLANK_SYNC_EN.
REQ-033 SHALL, when PAL_VBLANK_SYNC_EN is defined, permit drain only while vblank=1 (sampled each cycle), so palette updates land outside active video.
REQ-034 SHALL, when PAL_VBLANK_SYNC_EN is undefined, permit drain always and leave vblank unused.

Verification
REQ-035 SHALL cover, with SYNC_EN and vblank=0: 3 writes to 0x04000..0x04002 -> no pal_wrena, fifo_level=3; vblank=1 -> 3 consecutive pal_wrena in order, then IDLE.
REQ-036 SHALL cover writes to 0x03FFF and 0x04400 -> no enqueue, fifo_level=0, overflow=0.
REQ-037 SHALL cover 17 writes with vblank=0 and depth 16 -> fifo_full=1, overflow=1, first 16 drain intact; overflow_clr -> overflow=0.
REQ-038 SHALL cover 8 queued entries with vblank high for 3 cycles -> 3 writes, state ARMED, level=5; next vblank -> remaining 5 in order.
REQ-039 SHALL cover full queue with push+pop in the same cycle -> level=16, no overflow, pushed entry drains last.
REQ-040 SHALL cover reset_n=0 mid-drain -> pal_wrena=0, level=0, later vblank produces no writes; without SYNC_EN, a single write -> pal_wrena 2 cycles later.
